// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and a MAC byte helper for the ARP receive filter.
package eth_pkg;

   localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
   localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;
   localparam int          ETH_HDR_LEN   = 14;
   localparam int          ARP_HDR_LEN   = 8;

   // HTYPE=1, PTYPE=0x0800, HLEN=6, PLEN=4, OPER=1 (request)
   localparam logic [7:0] ARP_HDR_REQ [ARP_HDR_LEN] =
      '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_ARPH,
      ST_PASS,
      ST_DROP
   } state_t;

   // Byte idx of a MAC in wire order (0 = most significant byte).
   function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
      return mac[8*(5-int'(idx)) +: 8];
   endfunction

endpackage

// File: rtl/byte_delay_line.sv
// Fixed-depth byte shift register with a per-stage valid bit; flush empties it at once.
module byte_delay_line
   import eth_pkg::*;
#(
   parameter int DEPTH = 9
) (
   input  logic       i_clock,
   input  logic       i_sclr,
   input  logic       i_flush,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_fill
);

   logic [DEPTH-1:0] r_valid;
   logic [7:0]       r_data [DEPTH];

   // Valid bits shift with the data; reset or flush empties the line.
   always_ff @(posedge i_clock) begin
      if (i_sclr || i_flush) begin
         r_valid <= '0;
      end else begin
         r_valid <= {r_valid[DEPTH-2:0], i_valid};
      end
   end

   // Data stages need no reset: they are qualified by the valid bits.
   always_ff @(posedge i_clock) begin
      r_data[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
         r_data[k] <= r_data[k-1];
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];
   // High when the line will still hold a valid byte after the next edge.
   assign o_fill  = i_valid || (|r_valid[DEPTH-2:0]);

endmodule

// File: rtl/eth_arp_filter.sv
// Ethernet receive filter: validates header and ARP request header, then forwards
// the ARP payload as a gap-free burst delayed long enough to know the verdict.
module eth_arp_filter
   import eth_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC = 48'h020000000001,
   parameter int          CHECK_LEN = 8,
   parameter int          CNT_W     = 16
) (
   input  logic             i_clock,
   input  logic             i_sclr,
   input  logic             i_rx_en,
   input  logic [7:0]       i_rx_data,
   output logic             o_out_en,
   output logic [7:0]       o_out_data,
   output logic [CNT_W-1:0] o_arp_cnt,
   output logic [CNT_W-1:0] o_drop_cnt
);

   localparam int BC_W  = 12;
   localparam int DEPTH = CHECK_LEN + 1;

   state_t           r_state, w_state_next;
   logic [BC_W-1:0]  r_byte_cnt;
   logic [BC_W-1:0]  w_pay_off;
   logic             r_local_ok, r_bcast_ok;
   logic             w_local_ok_next, w_bcast_ok_next;
   logic             w_hdr_bad;
   logic             w_drop_inc, w_arp_inc, w_set_ok;
   logic             r_frame_ok;
   logic             w_pay_valid, w_flush;
   logic             w_line_valid, w_line_fill;
   logic [7:0]       w_line_data;
   logic             r_out_en;
   logic [7:0]       r_out_data;
   logic [CNT_W-1:0] r_arp_cnt, r_drop_cnt;

   assign w_pay_off   = r_byte_cnt - BC_W'(ETH_HDR_LEN);
   assign w_pay_valid = i_rx_en && (r_byte_cnt >= BC_W'(ETH_HDR_LEN));
   // A frame starting while the previous one still drains aborts that drain.
   assign w_flush     = (r_state == ST_IDLE) && i_rx_en;

   // Next-state logic, header checks and counter strobes.
   always_comb begin
      w_state_next    = r_state;
      w_local_ok_next = r_local_ok;
      w_bcast_ok_next = r_bcast_ok;
      w_hdr_bad       = 1'b0;
      w_drop_inc      = 1'b0;
      w_arp_inc       = 1'b0;
      w_set_ok        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_rx_en) begin
               // Byte 0 is only recorded here; a bad first MAC byte is caught on byte 1.
               w_state_next    = ST_HDR;
               w_local_ok_next = (i_rx_data == mac_byte(LOCAL_MAC, 3'd0));
               w_bcast_ok_next = (i_rx_data == mac_byte(MAC_BCAST, 3'd0));
            end
         end
         ST_HDR: begin
            if (!i_rx_en) begin
               w_state_next = ST_IDLE;
               w_drop_inc   = 1'b1;
            end else begin
               if (r_byte_cnt < BC_W'(6)) begin
                  w_local_ok_next = r_local_ok && (i_rx_data == mac_byte(LOCAL_MAC, r_byte_cnt[2:0]));
                  w_bcast_ok_next = r_bcast_ok && (i_rx_data == mac_byte(MAC_BCAST, r_byte_cnt[2:0]));
                  w_hdr_bad       = !(w_local_ok_next || w_bcast_ok_next);
               end else if (r_byte_cnt == BC_W'(12)) begin
                  w_hdr_bad = (i_rx_data != ETHERTYPE_ARP[15:8]);
               end else if (r_byte_cnt == BC_W'(13)) begin
                  w_hdr_bad = (i_rx_data != ETHERTYPE_ARP[7:0]);
               end
               if (w_hdr_bad) begin
                  w_state_next = ST_DROP;
                  w_drop_inc   = 1'b1;
               end else if (r_byte_cnt == BC_W'(ETH_HDR_LEN - 1)) begin
                  w_state_next = ST_ARPH;
               end
            end
         end
         ST_ARPH: begin
            if (!i_rx_en) begin
               w_state_next = ST_IDLE;
               w_drop_inc   = 1'b1;
            end else if (i_rx_data != ARP_HDR_REQ[w_pay_off[2:0]]) begin
               w_state_next = ST_DROP;
               w_drop_inc   = 1'b1;
            end else if (w_pay_off == BC_W'(CHECK_LEN - 1)) begin
               w_state_next = ST_PASS;
               w_set_ok     = 1'b1;
            end
         end
         ST_PASS: begin
            if (!i_rx_en) begin
               w_state_next = ST_IDLE;
               w_arp_inc    = 1'b1;
            end
         end
         ST_DROP: begin
            if (!i_rx_en) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_clock) begin
      if (i_sclr) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Frame byte index: saturating count of rx_en cycles, cleared between frames.
   always_ff @(posedge i_clock) begin
      if (i_sclr || !i_rx_en) begin
         r_byte_cnt <= '0;
      end else if (r_byte_cnt != '1) begin
         r_byte_cnt <= r_byte_cnt + BC_W'(1);
      end
   end

   // Running destination MAC match flags (local and broadcast tracked separately).
   always_ff @(posedge i_clock) begin
      if (i_sclr) begin
         r_local_ok <= 1'b0;
         r_bcast_ok <= 1'b0;
      end else begin
         r_local_ok <= w_local_ok_next;
         r_bcast_ok <= w_bcast_ok_next;
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge i_clock) begin
      if (i_sclr) begin
         r_arp_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_arp_inc && (r_arp_cnt != '1)) begin
            r_arp_cnt <= r_arp_cnt + CNT_W'(1);
         end
         if (w_drop_inc && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         end
      end
   end

   // frame_ok: set once the ARP header verifies, held until the last byte leaves the line.
   always_ff @(posedge i_clock) begin
      if (i_sclr || w_flush) begin
         r_frame_ok <= 1'b0;
      end else if (w_set_ok) begin
         r_frame_ok <= 1'b1;
      end else if ((r_state != ST_PASS) && !w_line_fill) begin
         r_frame_ok <= 1'b0;
      end
   end

   byte_delay_line #(
      .DEPTH (DEPTH)
   ) u_delay (
      .i_clock (i_clock),
      .i_sclr  (i_sclr),
      .i_flush (w_flush),
      .i_valid (w_pay_valid),
      .i_data  (i_rx_data),
      .o_valid (w_line_valid),
      .o_data  (w_line_data),
      .o_fill  (w_line_fill)
   );

   // Registered output stage; only bytes of an accepted frame are qualified.
   always_ff @(posedge i_clock) begin
      if (i_sclr || w_flush) begin
         r_out_en   <= 1'b0;
         r_out_data <= 8'h00;
      end else begin
         r_out_en   <= w_line_valid && r_frame_ok;
         r_out_data <= w_line_valid ? w_line_data : 8'h00;
      end
   end

   assign o_out_en   = r_out_en;
   assign o_out_data = r_out_data;
   assign o_arp_cnt  = r_arp_cnt;
   assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_eth_arp_filter.sv
// Directed + randomized bench for eth_arp_filter with a frame-level scoreboard.
module tb_eth_arp_filter;

   localparam logic [47:0] LOCAL_MAC = 48'h020000000001;
   localparam logic [47:0] BCAST     = 48'hFFFFFFFFFFFF;
   localparam logic [7:0]  REQ_HDR [8] = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};

   logic        clk = 1'b0;
   logic        sclr = 1'b0;
   logic        rx_en = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        out_en;
   logic [7:0]  out_data;
   logic [15:0] arp_cnt, drop_cnt;

   always #5 clk = ~clk;

   eth_arp_filter #(
      .LOCAL_MAC (LOCAL_MAC),
      .CHECK_LEN (8),
      .CNT_W     (16)
   ) dut (
      .i_clock    (clk),
      .i_sclr     (sclr),
      .i_rx_en    (rx_en),
      .i_rx_data  (rx_data),
      .o_out_en   (out_en),
      .o_out_data (out_data),
      .o_arp_cnt  (arp_cnt),
      .o_drop_cnt (drop_cnt)
   );

   typedef struct {
      int         c;
      logic [7:0] d;
   } ev_t;

   ev_t        q[$];          // expected output bytes with the edge they appear after
   logic [7:0] frm[$];        // frame under construction
   logic [7:0] burst[$];      // all bytes seen on the output since the last clear
   int n_pass = 0, n_total = 0, n_fail = 0;
   int cyc = 0;
   int exp_arp = 0, exp_drop = 0;
   int n_bursts = 0, cur_len = 0, first_out = -1, last_start = 0;
   bit prev_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, sample after the edge, score the output.
   task automatic step(input logic en, input logic [7:0] d, input logic rst);
      bit exp_en;
      sclr = rst; rx_en = en; rx_data = d;
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
         while (q.size() > 0 && q[$].c >= cyc) void'(q.pop_back());
         exp_arp = 0; exp_drop = 0;
      end
      exp_en = (q.size() > 0) && (q[0].c == cyc);
      check("out_en", {31'd0, out_en}, {31'd0, exp_en});
      if (exp_en) begin
         check("out_data", {24'd0, out_data}, {24'd0, q[0].d});
         void'(q.pop_front());
      end
      if (out_en === 1'b1) begin
         if (!prev_en) begin
            n_bursts++;
            cur_len = 0;
            if (first_out < 0) first_out = cyc;
         end
         cur_len++;
         burst.push_back(out_data);
      end
      prev_en = (out_en === 1'b1);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_arp_cnt"}, {16'd0, arp_cnt}, exp_arp);
      check({tag, "_drop_cnt"}, {16'd0, drop_cnt}, exp_drop);
   endtask

   task automatic clear_obs();
      burst.delete(); n_bursts = 0; cur_len = 0; first_out = -1;
   endtask

   task automatic do_reset();
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      clear_obs();
   endtask

   task automatic build_arp(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] oper,
                            input logic [31:0] spa, input logic [31:0] tpa, input int plen);
      logic [47:0] src;
      src = 48'h020000000099;
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
      frm.push_back(et[15:8]); frm.push_back(et[7:0]);
      frm.push_back(8'h00); frm.push_back(8'h01); frm.push_back(8'h08);
      frm.push_back(8'h00); frm.push_back(8'h06); frm.push_back(8'h04);
      frm.push_back(oper[15:8]); frm.push_back(oper[7:0]);
      for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
      for (int i = 0; i < 4; i++) frm.push_back(spa[31-8*i -: 8]);
      for (int i = 0; i < 6; i++) frm.push_back(8'h00);
      for (int i = 0; i < 4; i++) frm.push_back(tpa[31-8*i -: 8]);
      while (frm.size() < 14 + plen) frm.push_back(8'($urandom));
   endtask

   // Acceptance rule: long enough, our MAC or broadcast, ARP ethertype, request header.
   function automatic bit is_req();
      logic [47:0] dst;
      if (frm.size() < 22) return 1'b0;
      dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
      if (dst != LOCAL_MAC && dst != BCAST) return 1'b0;
      if ({frm[12], frm[13]} != 16'h0806) return 1'b0;
      for (int k = 0; k < 8; k++) if (frm[14+k] != REQ_HDR[k]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic send_frame(input int gap, input bit rst_last, input string name);
      int s;
      bit ok;
      s = cyc + 1;
      last_start = s;
      // A new frame aborts whatever of the previous burst has not yet appeared.
      while (q.size() > 0 && q[$].c >= s) void'(q.pop_back());
      ok = is_req();
      if (ok) begin
         for (int j = 0; j < frm.size() - 14; j++) q.push_back(ev_t'{c: s + 23 + j, d: frm[14+j]});
      end
      for (int i = 0; i < frm.size(); i++) step(1'b1, frm[i], rst_last && (i == frm.size() - 1));
      if (!rst_last) begin
         if (ok) begin
            if (exp_arp < 65535) exp_arp++;
         end else begin
            if (exp_drop < 65535) exp_drop++;
         end
      end
      for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), 1'b0);
      $display("frame %s len=%0d start=%0d request=%0d arp_cnt=%0d drop_cnt=%0d",
               name, frm.size(), s, ok, arp_cnt, drop_cnt);
      if (!rst_last) check_counts(name);
   endtask

   initial begin
      // Reset state
      do_reset();
      check_counts("reset");

      // T1: broadcast request, 46-byte payload
      build_arp(BCAST, 16'h0806, 16'h0001, 32'hC0A80002, 32'hC0A8000A, 46);
      send_frame(12, 1'b0, "T1");
      check("T1_bursts", n_bursts, 1);
      check("T1_len", burst.size(), 46);
      check("T1_latency", first_out - last_start, 23);
      check("T1_spa", {burst[14], burst[15], burst[16], burst[17]}, 32'hC0A80002);
      check("T1_tpa", {burst[24], burst[25], burst[26], burst[27]}, 32'hC0A8000A);

      // T2: IPv4 ethertype
      do_reset();
      build_arp(BCAST, 16'h0800, 16'h0001, 32'hC0A80002, 32'hC0A8000A, 46);
      send_frame(12, 1'b0, "T2");
      check("T2_bursts", n_bursts, 0);

      // T3: foreign MAC, then a reply
      do_reset();
      build_arp(48'h020000000002, 16'h0806, 16'h0001, 32'hC0A80002, 32'hC0A8000A, 46);
      send_frame(12, 1'b0, "T3a");
      build_arp(BCAST, 16'h0806, 16'h0002, 32'hC0A80002, 32'hC0A8000A, 46);
      send_frame(12, 1'b0, "T3b");
      check("T3_bursts", n_bursts, 0);
      check("T3_drop", {16'd0, drop_cnt}, 2);

      // T4: runt, then a good frame proves the FSM went back to idle
      do_reset();
      build_arp(LOCAL_MAC, 16'h0806, 16'h0001, 32'hC0A80003, 32'hC0A8000A, 46);
      while (frm.size() > 10) void'(frm.pop_back());
      send_frame(9, 1'b0, "T4a");
      check("T4_bursts", n_bursts, 0);
      build_arp(LOCAL_MAC, 16'h0806, 16'h0001, 32'hC0A80003, 32'hC0A8000A, 46);
      send_frame(12, 1'b0, "T4b");
      check("T4_len", burst.size(), 46);

      // T5: 12-cycle gap, then 2-cycle gap aborting a drain
      do_reset();
      build_arp(BCAST, 16'h0806, 16'h0001, 32'h0A000001, 32'h0A000002, 46);
      send_frame(12, 1'b0, "T5a");
      build_arp(LOCAL_MAC, 16'h0806, 16'h0001, 32'h0A000003, 32'h0A000004, 46);
      send_frame(12, 1'b0, "T5b");
      check("T5_bursts", n_bursts, 2);
      check("T5_len", burst.size(), 92);
      build_arp(BCAST, 16'h0806, 16'h0001, 32'h0A000005, 32'h0A000006, 46);
      send_frame(2, 1'b0, "T5c");
      build_arp(BCAST, 16'h0806, 16'h0001, 32'h0A000007, 32'h0A000008, 46);
      send_frame(12, 1'b0, "T5d");
      check("T5_bursts2", n_bursts, 4);
      check("T5_last_len", cur_len, 46);

      // T6: reset on the last byte of an accepted frame
      do_reset();
      build_arp(BCAST, 16'h0806, 16'h0001, 32'hC0A80002, 32'hC0A8000A, 46);
      send_frame(3, 1'b1, "T6a");
      check("T6_out_en", {31'd0, out_en}, 0);
      check("T6_seen", burst.size(), 36);
      check_counts("T6_rst");
      build_arp(BCAST, 16'h0806, 16'h0001, 32'hC0A80002, 32'hC0A8000A, 46);
      send_frame(12, 1'b0, "T6b");
      check("T6_last_len", cur_len, 46);

      // Randomized mix of frame kinds, lengths and gaps
      do_reset();
      for (int n = 0; n < 16; n++) begin
         int kind, plen, gap;
         logic [47:0] dst;
         kind = int'($urandom_range(0, 5));
         plen = int'($urandom_range(28, 60));
         gap  = int'($urandom_range(1, 14));
         dst  = ($urandom_range(0, 1) == 0) ? BCAST : LOCAL_MAC;
         case (kind)
            2: build_arp({8'h02, 8'($urandom), 32'($urandom)}, 16'h0806, 16'h0001, $urandom, $urandom, plen);
            3: build_arp(dst, 16'($urandom), 16'h0001, $urandom, $urandom, plen);
            4: build_arp(dst, 16'h0806, 16'h0002, $urandom, $urandom, plen);
            5: begin
               build_arp(dst, 16'h0806, 16'h0001, $urandom, $urandom, plen);
               if ($urandom_range(0, 1) == 0) begin
                  int idx;
                  idx = int'($urandom_range(0, 21));
                  frm[idx] = frm[idx] ^ 8'($urandom_range(1, 255));
               end else begin
                  int len;
                  len = int'($urandom_range(1, 21));
                  while (frm.size() > len) void'(frm.pop_back());
               end
            end
            default: build_arp(dst, 16'h0806, 16'h0001, $urandom, $urandom, plen);
         endcase
         send_frame(gap, 1'b0, $sformatf("R%0d", n));
      end
      for (int g = 0; g < 12; g++) step(1'b0, 8'h00, 1'b0);
      check("R_queue_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
